// File: rtl/biriscv_defs.sv
// Shared exception encodings and the CSR commit stage payload.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package biriscv_defs;

  localparam int EXCEPTION_W = 6;

  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_FETCH   = 6'h10;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_FETCH        = 6'h11;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_BREAKPOINT         = 6'h13;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_LOAD    = 6'h14;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_LOAD         = 6'h15;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_MISALIGNED_STORE   = 6'h16;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_STORE        = 6'h17;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ECALL              = 6'h18;
  localparam logic [EXCEPTION_W-1:0] EXCEPTION_ERET_M             = 6'h33;

  // One in-flight CSR/system instruction as it travels E2 -> WB.
  typedef struct packed {
    logic [31:0]            pc;
    logic [4:0]             rd_idx;
    logic [11:0]            csr_addr;
    logic                   csr_wen;
    logic [31:0]            value;
    logic                   write;
    logic [31:0]            wdata;
    logic [EXCEPTION_W-1:0] exception;
    logic [31:0]            exc_addr;
  } csr_stage_t;

endpackage

// File: rtl/biriscv_csr_pipe_reg.sv
// Generic valid+payload stage register with hold and kill.
// Latency: 1 cycle from in_* to vld_o/dat_o.
// Backpressure: hold_i freezes the occupant; kill_i drops it and wins over hold_i.
module biriscv_csr_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         hold_i,
  input  logic         kill_i,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  // Next state: kill empties the slot, hold keeps it, otherwise take the input.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (kill_i) begin
      vld_d = 1'b0;
    end else if (!hold_i) begin
      vld_d = in_vld_i;
      dat_d = in_dat_i;
    end
  end

  // Stage flops with synchronous clear of both valid and payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/biriscv_csr_commit.sv
// Carries CSR E1 results through E2 and WB, merges late faults, drives CSR and rd writeback.
// Latency: 2 cycles E1 -> WB outputs with no stall.
// Backpressure: stall_i holds E2/WB and gates commit strobes; squash_i/flush kill the E2 occupant.
module biriscv_csr_commit
  import biriscv_defs::*;
#(
  parameter int EXC_W              = 6,
  parameter bit SUPPORT_LATE_FAULT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             e1_valid_i,
  input  logic [31:0]      e1_pc_i,
  input  logic [4:0]       e1_rd_idx_i,
  input  logic [11:0]      e1_csr_addr_i,
  input  logic             e1_csr_wen_i,
  input  logic [31:0]      csr_result_e1_value_i,
  input  logic             csr_result_e1_write_i,
  input  logic [31:0]      csr_result_e1_wdata_i,
  input  logic [EXC_W-1:0] csr_result_e1_exception_i,
  input  logic [EXC_W-1:0] e2_fault_i,
  input  logic [31:0]      e2_fault_addr_i,
  input  logic             stall_i,
  input  logic             squash_i,
  output logic             csr_writeback_write_o,
  output logic [11:0]      csr_writeback_waddr_o,
  output logic [31:0]      csr_writeback_wdata_o,
  output logic [EXC_W-1:0] csr_writeback_exception_o,
  output logic [31:0]      csr_writeback_exception_pc_o,
  output logic [31:0]      csr_writeback_exception_addr_o,
  output logic             rd_wb_valid_o,
  output logic [4:0]       rd_wb_idx_o,
  output logic [31:0]      rd_wb_value_o,
  output logic             flush_o,
  output logic             busy_o
);

  localparam int STAGE_W = $bits(csr_stage_t);

  csr_stage_t             e1_dat;
  csr_stage_t             e2_dat;
  csr_stage_t             e2_merged;
  csr_stage_t             wb_dat;
  logic                   e2_vld;
  logic                   wb_vld;
  logic                   e2_kill;
  logic                   commit;
  logic                   wb_exc;
  logic                   flush;
  logic                   live;
  logic [EXC_W-1:0]       late_fault;

  // Pack the E1 result; the xtval slot is resolved later at the E2 -> WB merge.
  always_comb begin
    e1_dat           = '0;
    e1_dat.pc        = e1_pc_i;
    e1_dat.rd_idx    = e1_rd_idx_i;
    e1_dat.csr_addr  = e1_csr_addr_i;
    e1_dat.csr_wen   = e1_csr_wen_i;
    e1_dat.value     = csr_result_e1_value_i;
    e1_dat.write     = csr_result_e1_write_i;
    e1_dat.wdata     = csr_result_e1_wdata_i;
    e1_dat.exception = csr_result_e1_exception_i;
  end

  // A WB occupant commits only when the pipe is not stalled; an exception flushes.
  assign commit  = wb_vld & ~stall_i;
  assign wb_exc  = (wb_dat.exception != '0);
  assign flush   = commit & wb_exc;
  // Squash and flush both kill E2; OR-ing them keeps the combined case a single kill.
  assign e2_kill = squash_i | flush;

  biriscv_csr_pipe_reg #(.W(STAGE_W)) u_e2 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (stall_i),
    .kill_i   (e2_kill),
    .in_vld_i (e1_valid_i),
    .in_dat_i (e1_dat),
    .vld_o    (e2_vld),
    .dat_o    (e2_dat)
  );

  // Exception precedence: an early E1 exception beats any late E2 fault.
  always_comb begin
    e2_merged  = e2_dat;
    late_fault = SUPPORT_LATE_FAULT ? e2_fault_i : '0;
    if (e2_dat.exception != '0) begin
      // Illegal instruction reports the faulting opcode carried in value.
      e2_merged.exc_addr = (e2_dat.exception == EXCEPTION_ILLEGAL_INSTRUCTION) ?
                           e2_dat.value : 32'h0;
    end else if (late_fault != '0) begin
      e2_merged.exception = late_fault;
      e2_merged.exc_addr  = e2_fault_addr_i;
    end else begin
      e2_merged.exc_addr = 32'h0;
    end
  end

  // A killed E2 occupant never reaches WB.
  biriscv_csr_pipe_reg #(.W(STAGE_W)) u_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (stall_i),
    .kill_i   (1'b0),
    .in_vld_i (e2_vld & ~e2_kill),
    .in_dat_i (e2_merged),
    .vld_o    (wb_vld),
    .dat_o    (wb_dat)
  );

  // Outputs are forced low while reset is held so nothing leaks before the clearing edge.
  assign live = ~rst_i;

  assign csr_writeback_write_o          = live & commit & ~wb_exc & wb_dat.csr_wen & wb_dat.write;
  assign csr_writeback_waddr_o          = live ? wb_dat.csr_addr : 12'h0;
  assign csr_writeback_wdata_o          = live ? wb_dat.wdata : 32'h0;
  assign csr_writeback_exception_o      = (live & wb_vld) ? wb_dat.exception : '0;
  assign csr_writeback_exception_pc_o   = live ? wb_dat.pc : 32'h0;
  assign csr_writeback_exception_addr_o = live ? wb_dat.exc_addr : 32'h0;
  assign rd_wb_valid_o                  = live & commit & ~wb_exc & wb_dat.write &
                                          (wb_dat.rd_idx != 5'd0);
  assign rd_wb_idx_o                    = live ? wb_dat.rd_idx : 5'd0;
  assign rd_wb_value_o                  = live ? wb_dat.value : 32'h0;
  assign flush_o                        = live & flush;
  assign busy_o                         = live & (e2_vld | wb_vld);

endmodule

// File: tb/tb_biriscv_csr_commit.sv
// Self-checking bench for biriscv_csr_commit: directed scenarios then random traffic.
// Latency: expected outputs come from an in-flight instruction list, not a stage copy.
// Backpressure: stall/squash/reset are driven randomly and tracked by the list model.
module tb_biriscv_csr_commit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        e1_valid_i;
  logic [31:0] e1_pc_i;
  logic [4:0]  e1_rd_idx_i;
  logic [11:0] e1_csr_addr_i;
  logic        e1_csr_wen_i;
  logic [31:0] csr_result_e1_value_i;
  logic        csr_result_e1_write_i;
  logic [31:0] csr_result_e1_wdata_i;
  logic [5:0]  csr_result_e1_exception_i;
  logic [5:0]  e2_fault_i;
  logic [31:0] e2_fault_addr_i;
  logic        stall_i;
  logic        squash_i;
  logic        csr_writeback_write_o;
  logic [11:0] csr_writeback_waddr_o;
  logic [31:0] csr_writeback_wdata_o;
  logic [5:0]  csr_writeback_exception_o;
  logic [31:0] csr_writeback_exception_pc_o;
  logic [31:0] csr_writeback_exception_addr_o;
  logic        rd_wb_valid_o;
  logic [4:0]  rd_wb_idx_o;
  logic [31:0] rd_wb_value_o;
  logic        flush_o;
  logic        busy_o;

  biriscv_csr_commit dut (
    .clk_i                          (clk),
    .rst_i                          (rst_i),
    .e1_valid_i                     (e1_valid_i),
    .e1_pc_i                        (e1_pc_i),
    .e1_rd_idx_i                    (e1_rd_idx_i),
    .e1_csr_addr_i                  (e1_csr_addr_i),
    .e1_csr_wen_i                   (e1_csr_wen_i),
    .csr_result_e1_value_i          (csr_result_e1_value_i),
    .csr_result_e1_write_i          (csr_result_e1_write_i),
    .csr_result_e1_wdata_i          (csr_result_e1_wdata_i),
    .csr_result_e1_exception_i      (csr_result_e1_exception_i),
    .e2_fault_i                     (e2_fault_i),
    .e2_fault_addr_i                (e2_fault_addr_i),
    .stall_i                        (stall_i),
    .squash_i                       (squash_i),
    .csr_writeback_write_o          (csr_writeback_write_o),
    .csr_writeback_waddr_o          (csr_writeback_waddr_o),
    .csr_writeback_wdata_o          (csr_writeback_wdata_o),
    .csr_writeback_exception_o      (csr_writeback_exception_o),
    .csr_writeback_exception_pc_o   (csr_writeback_exception_pc_o),
    .csr_writeback_exception_addr_o (csr_writeback_exception_addr_o),
    .rd_wb_valid_o                  (rd_wb_valid_o),
    .rd_wb_idx_o                    (rd_wb_idx_o),
    .rd_wb_value_o                  (rd_wb_value_o),
    .flush_o                        (flush_o),
    .busy_o                         (busy_o)
  );

  always #5 clk = ~clk;

  // In-flight instruction record; age counts completed pipeline steps (1 = in E2, 2 = in WB).
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [11:0] addr;
    logic        wen;
    logic [31:0] value;
    logic        write;
    logic [31:0] wdata;
    logic [5:0]  exc;
    logic [31:0] xaddr;
    int          age;
  } rec_t;

  rec_t inflight[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_commit = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    e1_valid_i = 1'b0; stall_i = 1'b0; squash_i = 1'b0;
    e2_fault_i = 6'h0; e2_fault_addr_i = 32'h0;
  endtask

  task automatic set_e1(input logic [31:0] pc, input logic [4:0] rd, input logic [11:0] a,
                        input logic wen, input logic [31:0] val, input logic wr,
                        input logic [31:0] wd, input logic [5:0] exc);
    idle();
    e1_valid_i = 1'b1; e1_pc_i = pc; e1_rd_idx_i = rd; e1_csr_addr_i = a;
    e1_csr_wen_i = wen; csr_result_e1_value_i = val; csr_result_e1_write_i = wr;
    csr_result_e1_wdata_i = wd; csr_result_e1_exception_i = exc;
  endtask

  // Compare outputs against the list model, then advance one clock and update the model.
  task automatic tick();
    rec_t w, r, e;
    rec_t nq[$];
    bit   wbv, live, go, clean, fl;
    wbv = 1'b0;
    #1;
    foreach (inflight[i]) if (inflight[i].age == 2) begin w = inflight[i]; wbv = 1'b1; end
    live  = !rst_i;
    go    = live && wbv && !stall_i;
    clean = go && (w.exc == 6'h0);
    fl    = go && (w.exc != 6'h0);
    chk("csr_write", csr_writeback_write_o, clean && w.wen && w.write);
    chk("rd_valid",  rd_wb_valid_o, clean && w.write && (w.rd != 5'd0));
    chk("flush",     flush_o, fl);
    chk("exception", csr_writeback_exception_o, (live && wbv) ? w.exc : 6'h0);
    chk("busy",      busy_o, live && (inflight.size() != 0));
    if (live && wbv) begin
      chk("exc_pc",   csr_writeback_exception_pc_o, w.pc);
      chk("exc_addr", csr_writeback_exception_addr_o, w.xaddr);
      chk("waddr",    csr_writeback_waddr_o, w.addr);
      chk("wdata",    csr_writeback_wdata_o, w.wdata);
      chk("rd_idx",   rd_wb_idx_o, w.rd);
      chk("rd_value", rd_wb_value_o, w.value);
    end
    if (csr_writeback_write_o || rd_wb_valid_o) n_commit++;
    @(posedge clk);
    if (rst_i) begin
      inflight.delete();
    end else begin
      foreach (inflight[i]) begin
        r = inflight[i];
        if (r.age == 2) begin
          if (stall_i) nq.push_back(r);           // otherwise it retired this edge
        end else if (squash_i || fl) begin
          // younger instruction killed
        end else if (stall_i) begin
          nq.push_back(r);
        end else begin
          if (r.exc != 6'h0)
            r.xaddr = (r.exc == 6'h12) ? r.value : 32'h0;
          else if (e2_fault_i != 6'h0) begin
            r.exc = e2_fault_i; r.xaddr = e2_fault_addr_i;
          end else
            r.xaddr = 32'h0;
          r.age = 2;
          nq.push_back(r);
        end
      end
      if (e1_valid_i && !stall_i && !squash_i && !fl) begin
        e.pc = e1_pc_i; e.rd = e1_rd_idx_i; e.addr = e1_csr_addr_i; e.wen = e1_csr_wen_i;
        e.value = csr_result_e1_value_i; e.write = csr_result_e1_write_i;
        e.wdata = csr_result_e1_wdata_i; e.exc = csr_result_e1_exception_i;
        e.xaddr = 32'h0; e.age = 1;
        nq.push_back(e);
      end
      inflight = nq;
    end
    @(negedge clk);
  endtask

  logic [5:0] exc_pool [4];
  logic [5:0] flt_pool [2];

  initial begin
    exc_pool = '{6'h12, 6'h13, 6'h18, 6'h33};
    flt_pool = '{6'h15, 6'h17};
    set_e1(32'h0, 5'd0, 12'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'h0);
    idle();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    tick();                                             // cycle after deassert: all zero

    // CSRRW mscratch
    set_e1(32'h8000_0000, 5'd3, 12'h340, 1'b1, 32'h5, 1'b1, 32'hDEAD_BEEF, 6'h0);
    tick(); idle(); tick();
    #1;
    chk("csrrw_write", csr_writeback_write_o, 1'b1);
    chk("csrrw_waddr", csr_writeback_waddr_o, 12'h340);
    chk("csrrw_wdata", csr_writeback_wdata_o, 32'hDEAD_BEEF);
    chk("csrrw_rdv",   rd_wb_valid_o, 1'b1);
    chk("csrrw_idx",   rd_wb_idx_o, 5'd3);
    chk("csrrw_val",   rd_wb_value_o, 32'h5);
    chk("csrrw_flush", flush_o, 1'b0);
    tick();

    // Illegal CSR followed by a younger instruction that must be flushed
    set_e1(32'h8000_0010, 5'd5, 12'h300, 1'b1, 32'h3000_1073, 1'b1, 32'h0, 6'h12);
    tick();
    set_e1(32'h8000_0014, 5'd6, 12'h341, 1'b1, 32'h77, 1'b1, 32'h99, 6'h0);
    tick(); idle();
    n_commit = 0;
    #1;
    chk("ill_exc",   csr_writeback_exception_o, 6'h12);
    chk("ill_pc",    csr_writeback_exception_pc_o, 32'h8000_0010);
    chk("ill_addr",  csr_writeback_exception_addr_o, 32'h3000_1073);
    chk("ill_flush", flush_o, 1'b1);
    chk("ill_wr",    csr_writeback_write_o, 1'b0);
    chk("ill_rdv",   rd_wb_valid_o, 1'b0);
    tick(); tick(); tick();
    chk("ill_young_commits", n_commit, 0);

    // Late fault on a clean instruction
    set_e1(32'h8000_0020, 5'd7, 12'h305, 1'b0, 32'h1, 1'b1, 32'h0, 6'h0);
    tick(); idle();
    e2_fault_i = 6'h15; e2_fault_addr_i = 32'h1000_0004;
    tick(); idle();
    #1;
    chk("late_exc",  csr_writeback_exception_o, 6'h15);
    chk("late_addr", csr_writeback_exception_addr_o, 32'h1000_0004);
    tick();

    // Early exception beats late fault
    set_e1(32'h8000_0030, 5'd8, 12'h306, 1'b0, 32'h0000_0073, 1'b1, 32'h0, 6'h12);
    tick(); idle();
    e2_fault_i = 6'h15; e2_fault_addr_i = 32'h1000_0008;
    tick(); idle();
    #1;
    chk("prec_exc",  csr_writeback_exception_o, 6'h12);
    chk("prec_addr", csr_writeback_exception_addr_o, 32'h0000_0073);
    tick();

    // Stall three cycles with WB valid
    set_e1(32'h8000_0040, 5'd9, 12'h340, 1'b1, 32'hA5, 1'b1, 32'h1234, 6'h0);
    tick(); idle(); tick();
    n_commit = 0;
    stall_i = 1'b1;
    tick(); tick(); tick();
    chk("stall_no_strobe", n_commit, 0);
    stall_i = 1'b0;
    tick(); tick();
    chk("stall_one_commit", n_commit, 1);

    // Squash the E2 occupant while WB commits
    set_e1(32'h8000_0050, 5'd10, 12'h340, 1'b1, 32'h10, 1'b1, 32'h20, 6'h0);
    tick();
    set_e1(32'h8000_0054, 5'd11, 12'h341, 1'b1, 32'h11, 1'b1, 32'h21, 6'h0);
    tick(); idle();
    n_commit = 0;
    squash_i = 1'b1;
    #1;
    chk("sq_wb_idx", rd_wb_idx_o, 5'd10);
    tick();
    squash_i = 1'b0;
    tick(); tick();
    chk("sq_commits", n_commit, 1);

    // Reset with E2 and WB occupied
    set_e1(32'h8000_0060, 5'd12, 12'h340, 1'b1, 32'h1, 1'b1, 32'h2, 6'h0);
    tick();
    set_e1(32'h8000_0064, 5'd13, 12'h341, 1'b1, 32'h3, 1'b1, 32'h4, 6'h0);
    tick(); idle();
    n_commit = 0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst_busy", busy_o, 1'b0);
    tick(); tick();
    chk("rst_commits", n_commit, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_i      = ($urandom_range(0, 99) < 2);
      e1_valid_i = ($urandom_range(0, 9) < 7);
      e1_pc_i    = $urandom;
      e1_rd_idx_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      e1_csr_addr_i = 12'($urandom);
      e1_csr_wen_i  = $urandom_range(0, 1) == 1;
      csr_result_e1_value_i = $urandom;
      csr_result_e1_write_i = ($urandom_range(0, 3) != 0);
      csr_result_e1_wdata_i = $urandom;
      csr_result_e1_exception_i = ($urandom_range(0, 99) < 15) ? exc_pool[$urandom_range(0, 3)] : 6'h0;
      e2_fault_i      = ($urandom_range(0, 99) < 15) ? flt_pool[$urandom_range(0, 1)] : 6'h0;
      e2_fault_addr_i = $urandom;
      stall_i  = ($urandom_range(0, 99) < 20);
      squash_i = ($urandom_range(0, 99) < 10);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
